// File: rtl/capture_axil_regs.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit control registers with
// independent single-outstanding write and read paths and per-register commit pulses.
module capture_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] RESET_VALUE        = 32'h0
) (
  input  logic                                              ACLK,
  input  logic                                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     S_AXI_AWADDR,
  input  logic [2:0]                                        S_AXI_AWPROT,
  input  logic                                              S_AXI_AWVALID,
  output logic                                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                   S_AXI_WSTRB,
  input  logic                                              S_AXI_WVALID,
  output logic                                              S_AXI_WREADY,
  output logic [1:0]                                        S_AXI_BRESP,
  output logic                                              S_AXI_BVALID,
  input  logic                                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     S_AXI_ARADDR,
  input  logic [2:0]                                        S_AXI_ARPROT,
  input  logic                                              S_AXI_ARVALID,
  output logic                                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                     S_AXI_RDATA,
  output logic [1:0]                                        S_AXI_RRESP,
  output logic                                              S_AXI_RVALID,
  input  logic                                              S_AXI_RREADY,
  output logic [(2**(C_S_AXI_ADDR_WIDTH-2))*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [(2**(C_S_AXI_ADDR_WIDTH-2))-1:0]            reg_wr_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NUM_REGS = 2**IDX_W;

  logic             aw_held_q;
  logic             w_held_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [DW-1:0]    wdata_q;
  logic [DW/8-1:0]  wstrb_q;
  logic             bvalid_q;
  logic [NUM_REGS-1:0] pulse_q;
  logic             rvalid_q;
  logic [DW-1:0]    rdata_q;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [DW-1:0] wr_mask;
  logic [DW-1:0] rd_word;

  // Address LSBs and protection bits carry no meaning for this register file.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q && !ARESET;
  assign S_AXI_WREADY  = !w_held_q && !bvalid_q && !ARESET;
  assign S_AXI_ARREADY = !rvalid_q && !ARESET;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign reg_wr_pulse  = pulse_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_held_q && w_held_q;

  for (genvar gi = 0; gi < DW/8; gi++) begin : g_mask
    assign wr_mask[8*gi +: 8] = {8{wstrb_q[gi]}};
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DW-1:0] reg_q;
    logic [DW-1:0] reg_d;
    assign reg_d = (reg_q & ~wr_mask) | (wdata_q & wr_mask);
    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        reg_q <= RESET_VALUE;
      end else if (commit && (wr_idx_q == IDX_W'(gi))) begin
        reg_q <= reg_d;
      end
    end
    assign reg_out[DW*gi +: DW] = reg_q;
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] == IDX_W'(i)) begin
        rd_word = reg_out[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      wr_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      pulse_q   <= '0;
    end else begin
      pulse_q <= '0;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        wr_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      // Handshakes are blocked while holding or responding, so commit never overlaps them.
      if (commit) begin
        aw_held_q         <= 1'b0;
        w_held_q          <= 1'b0;
        bvalid_q          <= 1'b1;
        pulse_q[wr_idx_q] <= 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read samples the register array before any same-edge commit lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_capture_axil_regs.sv
// Directed plus randomized bench for capture_axil_regs against a word-array model.
module tb_capture_axil_regs;

  localparam int NUM = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [NUM*32-1:0] reg_out;
  logic [NUM-1:0]    reg_wr_pulse;

  capture_axil_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [NUM];
  int pulse_cnt [NUM];
  int base_cnt  [NUM];

  always @(negedge ACLK) begin
    for (int i = 0; i < NUM; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;
  end

  function automatic logic [31:0] word(input int i);
    return reg_out[i*32 +: 32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_aw(input logic [3:0] addr, input int delay);
    int n = 0;
    @(posedge ACLK);
    repeat (delay) @(posedge ACLK);
    #1;
    S_AXI_AWADDR  = addr;
    S_AXI_AWVALID = 1'b1;
    do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 60);
    if (!S_AXI_AWREADY) check("aw_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
    int n = 0;
    @(posedge ACLK);
    repeat (delay) @(posedge ACLK);
    #1;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    S_AXI_WVALID = 1'b1;
    do begin @(negedge ACLK); n++; end while (!S_AXI_WREADY && n < 60);
    if (!S_AXI_WREADY) check("w_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic do_aw_w(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awd, input int wd);
    fork
      send_aw(addr, awd);
      send_w(data, strb, wd);
    join
  endtask

  // Called right after the later of the two handshakes: BVALID rises one edge later.
  task automatic wait_commit(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr[3:2]);
    for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    @(negedge ACLK);
    check("bvalid_not_early", {31'd0, S_AXI_BVALID}, 32'd0);
    @(negedge ACLK);
    check("bvalid_after_commit", {31'd0, S_AXI_BVALID}, 32'd1);
    check("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
    check($sformatf("reg%0d_after_commit", idx), word(idx), model[idx]);
    check("wr_pulse_onehot", {28'd0, reg_wr_pulse}, 32'd1 << idx);
    $display("write addr=%h data=%h strb=%b -> reg%0d=%h", addr, data, strb, idx, word(idx));
  endtask

  task automatic b_handshake(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge ACLK);
      check("bvalid_hold", {29'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'b100);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("bvalid_cleared", {31'd0, S_AXI_BVALID}, 32'd0);
    check("wr_pulse_cleared", {28'd0, reg_wr_pulse}, 32'd0);
  endtask

  task automatic write_full(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awd, input int wd, input int bd);
    do_aw_w(addr, data, strb, awd, wd);
    wait_commit(addr, data, strb);
    b_handshake(bd);
  endtask

  task automatic read_chk(input logic [3:0] addr, input int rd);
    int n = 0;
    logic [31:0] exp = model[int'(addr[3:2])];
    @(posedge ACLK); #1;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 60);
    if (!S_AXI_ARREADY) check("ar_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check("rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
    check($sformatf("rdata_%h", addr), S_AXI_RDATA, exp);
    check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
    $display("read  addr=%h data=%h expected=%h", addr, S_AXI_RDATA, exp);
    for (int i = 0; i < rd; i++) begin
      @(negedge ACLK);
      check("rdata_hold", S_AXI_RDATA, exp);
      check("rhold_flags", {30'd0, S_AXI_RVALID, S_AXI_ARREADY}, 32'b10);
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    check("r_done_flags", {30'd0, S_AXI_RVALID, S_AXI_ARREADY}, 32'b01);
  endtask

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    for (int i = 0; i < NUM; i++) begin model[i] = 32'h0; pulse_cnt[i] = 0; end

    // Reset held for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      check("in_reset_flags", {26'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                               S_AXI_BVALID, S_AXI_RVALID, |reg_wr_pulse}, 32'd0);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    check("ready_after_reset", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'b111);
    check("rdata_reset", S_AXI_RDATA, 32'd0);
    for (int i = 0; i < NUM; i++) check($sformatf("reg%0d_reset", i), word(i), 32'h0);

    // Sequential writes then reads.
    for (int i = 0; i < NUM; i++) base_cnt[i] = pulse_cnt[i];
    for (int i = 0; i < NUM; i++) write_full(4'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NUM; i++) read_chk(4'(i*4), 0);
    for (int i = 0; i < NUM; i++) check($sformatf("pulse_count%0d", i), 32'(pulse_cnt[i] - base_cnt[i]), 32'd1);

    // Decoupled channels.
    write_full(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    write_full(4'h4, 32'h12345678, 4'hF, 0, 2, 0);
    check("reg2_decoupled", word(2), 32'hDEADBEEF);
    check("reg1_decoupled", word(1), 32'h12345678);

    // Byte strobes.
    write_full(4'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    write_full(4'hC, 32'h00AB00CD, 4'b0101, 1, 0, 0);
    check("reg3_strobe", word(3), 32'hFFABFFCD);
    write_full(4'hC, 32'h12345678, 4'b0000, 0, 1, 0);
    check("reg3_nostrobe", word(3), 32'hFFABFFCD);

    // Write-response backpressure with a second write pending.
    do_aw_w(4'h0, 32'hA5A5A5A5, 4'hF, 0, 0);
    wait_commit(4'h0, 32'hA5A5A5A5, 4'hF);
    fork
      do_aw_w(4'h4, 32'h0BADF00D, 4'hF, 0, 0);
      begin
        for (int i = 0; i < 10; i++) begin
          check("bp_flags", {29'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'b100);
          check("bp_reg1_unchanged", word(1), model[1]);
          @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
      end
    join
    wait_commit(4'h4, 32'h0BADF00D, 4'hF);
    b_handshake(0);
    read_chk(4'h6, 6);

    // Collision: AR handshake on the same edge as the commit to reg0.
    write_full(4'h0, 32'h11, 4'hF, 0, 0, 0);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    check("coll_wready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'b11);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    check("coll_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check("coll_rdata_old", S_AXI_RDATA, 32'h11);
    check("coll_valids", {30'd0, S_AXI_RVALID, S_AXI_BVALID}, 32'b11);
    check("coll_reg0_new", word(0), 32'h55);
    $display("collide addr=0 rdata=%h reg0=%h", S_AXI_RDATA, word(0));
    model[0] = 32'h55;
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("coll_done", {30'd0, S_AXI_RVALID, S_AXI_BVALID}, 32'd0);
    read_chk(4'h0, 0);

    // Randomized writes and reads against the model.
    for (int it = 0; it < 24; it++) begin
      a = 4'($urandom_range(15, 0));
      d = $urandom;
      write_full(a, d, 4'($urandom_range(15, 0)), $urandom_range(3, 0), $urandom_range(3, 0),
                 $urandom_range(2, 0));
      read_chk(4'($urandom_range(15, 0)), $urandom_range(2, 0));
    end

    // Reset while a write response is outstanding.
    do_aw_w(4'h0, 32'h77, 4'hF, 0, 0);
    wait_commit(4'h0, 32'h77, 4'hF);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
    check("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    for (int i = 0; i < NUM; i++) check($sformatf("reg%0d_midreset", i), word(i), 32'h0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < NUM; i++) model[i] = 32'h0;
    @(negedge ACLK);
    check("ready_after_rst2", {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                               S_AXI_BVALID, S_AXI_RVALID}, 32'b11100);
    read_chk(4'h0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/capture_axil_regs.md
Name: capture_axil_regs

Overview:
AXI4-Lite slave register file: the responder end of the control port that the verification master drives. It terminates single-beat AXI4-Lite writes and reads into NUM_REGS 32-bit control registers, exports them to capture logic, and emits a one-cycle write-strobe pulse per register. One outstanding write and one outstanding read are supported, handled independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte-address width; NUM_REGS = 2**(C_S_AXI_ADDR_WIDTH-2).
RESET_VALUE, 32'h0, reset value of every register.

Ports:
ACLK  in  1  clock
ARESET  in  1  reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response, always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  register contents; reg i at [32*i+31:32*i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on commit to reg i

Behaviour:
- Interface: one clock (ACLK); reset (ARESET) is synchronous and active-high.
- Reset: all registers = RESET_VALUE; AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_wr_pulse = 0; RDATA = 0; BRESP = RRESP = 0; write-side latches cleared. Reset mid-transaction abandons it, and no response is issued.
- Address decode: index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] ignored; full decode, no SLVERR.
- Write path:
  - State flags aw_held and w_held.
  - AWREADY = !aw_held && !BVALID && !ARESET, registered-state driven, no combinational path from VALID.
  - WREADY = !w_held && !BVALID && !ARESET, same rule.
  - AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - Commit: on the first edge where both flags are set, apply WSTRB byte-wise to reg[index], clear both flags, set BVALID, and pulse reg_wr_pulse[index] for exactly that following cycle.
  - Result: AW+W same-cycle handshake at edge k -> reg_out updated and BVALID high after edge k+1.
  - BVALID holds until the BREADY handshake; no new AW/W is accepted while BVALID is high.
  - WSTRB = 0 still commits (register unchanged), still pulses, and still responds.
- Read path:
  - ARREADY = !RVALID && !ARESET.
  - On an AR handshake at edge k, RDATA <= reg[index] sampled at edge k; RVALID high after edge k.
  - RDATA and RVALID hold stable until the RREADY handshake.
  - Back-to-back reads: ARREADY returns the cycle after the R handshake.
- Simultaneous events:
  - Read and write paths are independent.
  - A read whose AR handshake coincides with a write commit to the same register returns the pre-write value.
  - A read accepted after the commit edge returns the new value.
- reg_out is a direct register output: 0-cycle lag from the internal register.

Test Plan:
- Reset: hold ARESET 20 cycles, release -> all ready/valid = 0 during reset; AWREADY = WREADY = ARREADY = 1 in the first cycle after release; reg_out = 0.
- Sequential writes and reads: write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read 0x0..0xC -> each BRESP = OKAY, RDATA = 1,2,3,4, and reg_wr_pulse bits 0..3 each pulse exactly once.
- Decoupled channels: W(0xDEADBEEF) 3 cycles before AW(0x8); then AW 2 cycles before W(0x12345678) to 0x4 -> reg2 = 0xDEADBEEF, reg1 = 0x12345678, one BVALID per write.
- Byte strobes: reg3 = 0xFFFFFFFF, write 0x00AB00CD with WSTRB = 4'b0101 -> reg3 = 0xFFABFFCD; WSTRB = 0 -> value unchanged but BVALID issued.
- Backpressure: hold BREADY = 0 for 10 cycles with a second AW/W pending -> BVALID stays high, AWREADY/WREADY stay low, second write commits only after the B handshake. Hold RREADY = 0 -> RDATA stable, ARREADY low.
- Collision and reset: write 0x55 to 0x0 committing on the same edge as the AR handshake for 0x0 (prior value 0x11) -> RDATA = 0x11, next read = 0x55. Assert ARESET while BVALID = 1 -> BVALID = 0 next cycle and reg0 = RESET_VALUE.
